instr_fetch_stage: RTL

Instruction fetch stage of the MIPS datapath, directly upstream of the immediate extender. It holds the PC, fetches one instruction word at a time over a request/acknowledge instruction-memory port, and registers the word into an IF/ID output slot with a valid/ready handshake toward decode. It also pre-decodes the 16-bit immediate and the extender's sign-select control, so the extender receives both from registers. Branch and jump redirects flush the slot, and any in-flight fetch is discarded.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/imm_sign_decode.sv | 12 +
 rtl/instr_fetch_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, immediate-class
// opcodes and the reset PC.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Logical immediates and lui take their 16-bit field unsigned.
  function automatic logic is_zero_ext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/imm_sign_decode.sv
// Immediate extender sign select from the primary opcode: 1 = sign-extend,
// 0 = zero-extend.
module imm_sign_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       ext_sign
);

  assign ext_sign = !is_zero_ext_op(opcode);

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch: PC, req/ack instruction-memory port and a single IF/ID
// slot with valid/ready toward decode, with redirect flush of in-flight fetches.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [15:0] id_imm_16,
  output logic        id_ext_sign
);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_redir_pc, w_redir_pc_nxt;
  logic [31:0]  w_pc_plus4;
  logic         w_slot_free;
  logic         w_load;
  logic         w_ext_sign;

  logic         r_id_valid;
  logic [31:0]  r_id_instr;
  logic [31:0]  r_id_pc;
  logic [31:0]  r_id_pc_plus4;
  logic [15:0]  r_id_imm_16;
  logic         r_id_ext_sign;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_slot_free = !r_id_valid || id_ready;

  imm_sign_decode u_imm_sign_decode (
    .opcode   (imem_rdata[31:26]),
    .ext_sign (w_ext_sign)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_redir_pc_nxt = r_redir_pc;
    w_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (redirect_valid)
          w_pc_nxt = redirect_pc;
        else if (w_slot_free)
          w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid && imem_ack) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = ST_IDLE;
        end else if (redirect_valid) begin
          w_redir_pc_nxt = redirect_pc;
          w_state_nxt    = ST_DROP;
        end else if (imem_ack) begin
          w_load      = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        // Keep the old address on the bus until the stale response drains.
        if (redirect_valid)
          w_redir_pc_nxt = redirect_pc;
        if (imem_ack) begin
          w_pc_nxt    = redirect_valid ? redirect_pc : r_redir_pc;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_redir_pc <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redir_pc <= w_redir_pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid    <= 1'b0;
      r_id_instr    <= 32'd0;
      r_id_pc       <= 32'd0;
      r_id_pc_plus4 <= 32'd0;
      r_id_imm_16   <= 16'd0;
      r_id_ext_sign <= 1'b0;
    end else begin
      if (redirect_valid)
        r_id_valid <= 1'b0;
      else if (w_load)
        r_id_valid <= 1'b1;
      else if (r_id_valid && id_ready)
        r_id_valid <= 1'b0;
      if (w_load) begin
        r_id_instr    <= imem_rdata;
        r_id_pc       <= r_pc;
        r_id_pc_plus4 <= w_pc_plus4;
        r_id_imm_16   <= imem_rdata[15:0];
        r_id_ext_sign <= w_ext_sign;
      end
    end
  end

  assign imem_req    = (r_state != ST_IDLE);
  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_imm_16   = r_id_imm_16;
  assign id_ext_sign = r_id_ext_sign;

endmodule
